// File: rtl/clks_alot_generator_pkg.sv
// rtl/clks_alot_generator_pkg.sv - shared types for the generated/recovered clock state bundle
package clks_alot_p;

    localparam int RATE_COUNTER_WIDTH = 32;

    typedef logic [RATE_COUNTER_WIDTH-1:0] rate_t;
    typedef logic [RATE_COUNTER_WIDTH:0]   period_t;

    typedef struct packed {
        logic rising_edge;
        logic steady_high;
        logic falling_edge;
        logic steady_low;
    } generated_events_s;

    typedef struct packed {
        logic  pause_active;
        rate_t pause_duration;
        logic  locked;
    } status_s;

    typedef struct packed {
        logic              clk;
        status_s           status;
        generated_events_s events;
    } clock_state_s;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        PAUSE
    } gen_state_e;

    typedef struct packed {
        logic  even_50_50_en;
        rate_t high_rate_minus_one;
        rate_t low_rate_minus_one;
    } gen_conf_s;

    function automatic rate_t low_phase_minus_one(gen_conf_s conf);
        return conf.even_50_50_en ? conf.high_rate_minus_one : conf.low_rate_minus_one;
    endfunction

    // Full period length minus one; the extra bit keeps the sum from wrapping.
    function automatic period_t period_minus_one(gen_conf_s conf);
        return {1'b0, conf.high_rate_minus_one} + {1'b0, low_phase_minus_one(conf)} + period_t'(1);
    endfunction

endpackage

// File: rtl/clks_alot_generator_phase_counter.sv
// rtl/clks_alot_generator_phase_counter.sv - loadable down-counter with zero flag
module clks_alot_phase_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/clks_alot_generator.sv
// rtl/clks_alot_generator.sv - programmable clock synthesiser with pause, lock and edge events
module clks_alot_generator
    import clks_alot_p::*;
(
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         enable_i,
    input  logic         pause_req_i,
    input  logic         even_50_50_en_i,
    input  rate_t        high_rate_minus_one_i,
    input  rate_t        low_rate_minus_one_i,
    output clock_state_s clock_state_o
);

    gen_state_e state_q, state_d;
    gen_conf_s  conf_q, conf_d, conf_in;
    logic       clk_q, rise_q, fall_q, steady_high_q, steady_low_q;
    logic       pause_active_q, locked_q, locked_d;
    rate_t      pause_duration_q, pause_duration_d;

    logic       period_start, phase_load, phase_dec, phase_zero;
    logic       pause_entry, pause_load, pause_dec, pause_zero;
    logic       fall_d;
    rate_t      phase_load_value;

    assign conf_in = '{even_50_50_en: even_50_50_en_i,
                       high_rate_minus_one: high_rate_minus_one_i,
                       low_rate_minus_one: low_rate_minus_one_i};

    always_comb begin
        state_d      = state_q;
        period_start = 1'b0;
        phase_dec    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d      = HIGH;
                    period_start = 1'b1;
                end
            end
            HIGH: begin
                if (phase_zero) begin
                    state_d = LOW;
                end else begin
                    phase_dec = 1'b1;
                end
            end
            LOW: begin
                // Run controls only matter on the last low cycle so no runt phase is ever emitted.
                if (phase_zero) begin
                    if (!enable_i) begin
                        state_d = IDLE;
                    end else if (pause_req_i) begin
                        state_d = PAUSE;
                    end else begin
                        state_d      = HIGH;
                        period_start = 1'b1;
                    end
                end else begin
                    phase_dec = 1'b1;
                end
            end
            PAUSE: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (!pause_req_i) begin
                    state_d      = HIGH;
                    period_start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign phase_load       = period_start || ((state_q == HIGH) && phase_zero);
    assign phase_load_value = period_start ? high_rate_minus_one_i : low_phase_minus_one(conf_q);

    clks_alot_phase_counter #(.WIDTH(RATE_COUNTER_WIDTH)) u_phase_counter (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .load_i       (phase_load),
        .load_value_i (phase_load_value),
        .dec_i        (phase_dec),
        .zero_o       (phase_zero)
    );

    // Virtual-period timer: reloads each time one would-be period elapses while paused.
    assign pause_entry = (state_d == PAUSE) && (state_q != PAUSE);
    assign pause_load  = pause_entry || ((state_q == PAUSE) && pause_zero);
    assign pause_dec   = (state_q == PAUSE) && !pause_zero;

    clks_alot_phase_counter #(.WIDTH(RATE_COUNTER_WIDTH + 1)) u_pause_counter (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .load_i       (pause_load),
        .load_value_i (period_minus_one(conf_q)),
        .dec_i        (pause_dec),
        .zero_o       (pause_zero)
    );

    always_comb begin
        conf_d           = period_start ? conf_in : conf_q;
        pause_duration_d = pause_duration_q;
        if (pause_entry) begin
            pause_duration_d = '0;
        end else if ((state_q == PAUSE) && pause_zero && (pause_duration_q != '1)) begin
            pause_duration_d = pause_duration_q + 1'b1;
        end
        locked_d = locked_q;
        if (period_start) begin
            locked_d = (state_q == LOW) && (conf_in == conf_q);
        end
        if (pause_entry || ((state_d == IDLE) && (state_q != IDLE))) begin
            locked_d = 1'b0;
        end
        fall_d = (state_q == HIGH) && (state_d == LOW);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q          <= IDLE;
            conf_q           <= '0;
            clk_q            <= 1'b0;
            rise_q           <= 1'b0;
            fall_q           <= 1'b0;
            steady_high_q    <= 1'b0;
            steady_low_q     <= 1'b1;
            pause_active_q   <= 1'b0;
            pause_duration_q <= '0;
            locked_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            conf_q           <= conf_d;
            clk_q            <= (state_d == HIGH);
            rise_q           <= period_start;
            fall_q           <= fall_d;
            steady_high_q    <= (state_d == HIGH) && !period_start;
            steady_low_q     <= (state_d != HIGH) && !fall_d;
            pause_active_q   <= (state_d == PAUSE);
            pause_duration_q <= pause_duration_d;
            locked_q         <= locked_d;
        end
    end

    assign clock_state_o = '{clk: clk_q,
                             status: '{pause_active: pause_active_q,
                                       pause_duration: pause_duration_q,
                                       locked: locked_q},
                             events: '{rising_edge: rise_q,
                                       steady_high: steady_high_q,
                                       falling_edge: fall_q,
                                       steady_low: steady_low_q}};

endmodule

// File: tb/tb_clks_alot_generator.sv
// tb/tb_clks_alot_generator.sv - scoreboard bench with waveform-queue reference model
module tb_clks_alot_generator;
    import clks_alot_p::*;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         enable_i, pause_req_i, even_50_50_en_i;
    rate_t        high_rate_minus_one_i, low_rate_minus_one_i;
    clock_state_s clock_state_o;

    int errors = 0;
    int checks = 0;

    clks_alot_generator dut (
        .sys_clk               (sys_clk),
        .sys_rst               (sys_rst),
        .enable_i              (enable_i),
        .pause_req_i           (pause_req_i),
        .even_50_50_en_i       (even_50_50_en_i),
        .high_rate_minus_one_i (high_rate_minus_one_i),
        .low_rate_minus_one_i  (low_rate_minus_one_i),
        .clock_state_o         (clock_state_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum {M_IDLE, M_RUN, M_PAUSE} m_mode_e;

    clock_state_s exp_q[$];
    bit           wave_q[$];
    m_mode_e      m_mode;
    gen_conf_s    m_conf;
    logic         m_clk, m_rise, m_fall, m_pa, m_lock;
    rate_t        m_pdur;
    longint       m_pcyc;

    task automatic go_idle();
        m_mode = M_IDLE; m_clk = 1'b0; m_pa = 1'b0; m_lock = 1'b0;
        wave_q.delete();
    endtask

    task automatic go_pause();
        m_mode = M_PAUSE; m_clk = 1'b0; m_pa = 1'b1; m_lock = 1'b0;
        m_pdur = '0; m_pcyc = 0;
    endtask

    // One whole period is laid out as a list of levels at its start.
    task automatic start_period(input bit from_run);
        gen_conf_s nc;
        int        hi, lo;
        nc = '{even_50_50_en: even_50_50_en_i, high_rate_minus_one: high_rate_minus_one_i,
               low_rate_minus_one: low_rate_minus_one_i};
        m_lock = from_run && (nc == m_conf);
        m_conf = nc;
        hi = int'(nc.high_rate_minus_one) + 1;
        lo = (nc.even_50_50_en ? int'(nc.high_rate_minus_one) : int'(nc.low_rate_minus_one)) + 1;
        wave_q.delete();
        for (int i = 0; i < hi; i++) wave_q.push_back(1'b1);
        for (int i = 0; i < lo; i++) wave_q.push_back(1'b0);
        m_clk  = wave_q.pop_front();
        m_rise = 1'b1;
        m_pa   = 1'b0;
        m_mode = M_RUN;
    endtask

    function automatic longint model_period();
        longint lo;
        lo = m_conf.even_50_50_en ? longint'(m_conf.high_rate_minus_one) : longint'(m_conf.low_rate_minus_one);
        return longint'(m_conf.high_rate_minus_one) + 1 + lo + 1;
    endfunction

    always @(posedge sys_clk) begin : model
        clock_state_s e;
        bit           nxt;
        if (sys_rst) begin
            go_idle();
            m_rise = 1'b0; m_fall = 1'b0; m_pdur = '0; m_conf = '0; m_pcyc = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            case (m_mode)
                M_IDLE: if (enable_i) start_period(1'b0);
                M_RUN: begin
                    if (wave_q.size() > 0) begin
                        nxt    = wave_q.pop_front();
                        m_fall = m_clk && !nxt;
                        m_clk  = nxt;
                    end else if (!enable_i) go_idle();
                    else if (pause_req_i) go_pause();
                    else start_period(1'b1);
                end
                default: begin
                    m_pcyc++;
                    if ((m_pcyc % model_period()) == 0 && m_pdur != '1) m_pdur = m_pdur + 1'b1;
                    if (!enable_i) go_idle();
                    else if (!pause_req_i) start_period(1'b0);
                end
            endcase
        end
        e.clk                   = m_clk;
        e.status.pause_active   = m_pa;
        e.status.pause_duration = m_pdur;
        e.status.locked         = m_lock;
        e.events.rising_edge    = m_rise;
        e.events.steady_high    = m_clk && !m_rise;
        e.events.falling_edge   = m_fall;
        e.events.steady_low     = !m_clk && !m_fall;
        exp_q.push_back(e);
    end

    bit seen = 1'b0;
    always @(negedge sys_clk) begin : monitor
        clock_state_s e;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            seen = 1'b1;
            checks++;
            if (clock_state_o !== e) begin
                errors++;
                $display("FAIL clock_state t=%0t: got %h required %h", $time, clock_state_o, e);
            end
        end else if (seen) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0t: got 0 entries required 1", $time);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        sys_rst = 1'b1; enable_i = 1'b1; pause_req_i = 1'b0; even_50_50_en_i = 1'b0;
        high_rate_minus_one_i = 2; low_rate_minus_one_i = 1;
        cyc(3);
        sys_rst = 1'b0;
        cyc(30);
        high_rate_minus_one_i = 3; low_rate_minus_one_i = 0; even_50_50_en_i = 1'b1;
        cyc(12);
        low_rate_minus_one_i = 7;
        cyc(24);
        even_50_50_en_i = 1'b0; high_rate_minus_one_i = 1; low_rate_minus_one_i = 1;
        cyc(21);
        high_rate_minus_one_i = 4;
        cyc(30);
        high_rate_minus_one_i = 1; low_rate_minus_one_i = 2;
        cyc(15);
        pause_req_i = 1'b1;
        cyc(25);
        pause_req_i = 1'b0;
        cyc(30);
        high_rate_minus_one_i = 0; low_rate_minus_one_i = 0;
        cyc(11);
        enable_i = 1'b0;
        cyc(10);
        enable_i = 1'b1;
        high_rate_minus_one_i = 3;
        cyc(6);
        sys_rst = 1'b1;
        cyc(1);
        sys_rst = 1'b0;
        cyc(20);
        for (int i = 0; i < 4000; i++) begin
            @(negedge sys_clk);
            if ($urandom_range(0, 15) == 0) enable_i = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 11) == 0) pause_req_i = $urandom_range(0, 1);
            if ($urandom_range(0, 19) == 0) high_rate_minus_one_i = $urandom_range(0, 4);
            if ($urandom_range(0, 19) == 0) low_rate_minus_one_i = $urandom_range(0, 4);
            if ($urandom_range(0, 39) == 0) even_50_50_en_i = $urandom_range(0, 1);
            sys_rst = ($urandom_range(0, 999) == 0);
        end
        sys_rst = 1'b0;
        enable_i = 1'b0;
        cyc(30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
